// File: rtl/iccm_loader_pkg.sv
// iccm_loader_pkg: shared state type and parameter defaults for the ICCM program loader.
package iccm_loader_pkg;
   typedef enum logic [1:0] {LOAD, DONE, ERR} state_e;
   localparam int unsigned AddrWDef   = 12;
   localparam logic [31:0] EndWordDef = 32'h0000_0FFF;
endpackage

// File: rtl/iccm_word_packer.sv
// iccm_word_packer: packs a byte stream little-endian into 32-bit words.
module iccm_word_packer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic        valid_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_valid_o
);
   logic [1:0]  idx_q, idx_d;
   logic [31:0] asm_q, asm_d;
   always_comb begin
      asm_d = asm_q;
      idx_d = idx_q;
      if (clr_i) begin
         asm_d = '0;
         idx_d = '0;
      end else if (en_i && valid_i) begin
         asm_d[{idx_q, 3'b000} +: 8] = byte_i;
         idx_d = idx_q + 2'd1;
      end
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         idx_q <= '0;
         asm_q <= '0;
      end else begin
         idx_q <= idx_d;
         asm_q <= asm_d;
      end
   end
   // The completed word includes the byte arriving this cycle.
   assign word_o       = asm_d;
   assign word_valid_o = en_i && valid_i && !clr_i && (idx_q == 2'd3);
endmodule

// File: rtl/iccm_loader.sv
// iccm_loader: fills the ICCM from a byte stream, then releases the program reset.
module iccm_loader
   import iccm_loader_pkg::*;
#(
   parameter int unsigned AddrW   = AddrWDef,
   parameter logic [31:0] EndWord = EndWordDef
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [7:0]       rx_byte_i,
   input  logic             rx_valid_i,
   input  logic             prog_req_i,
   output logic [AddrW-1:0] iccm_ctrl_addr_o,
   output logic [31:0]      iccm_ctrl_wdata_o,
   output logic             iccm_ctrl_we_o,
   output logic             prog_rst_no,
   output logic [AddrW:0]   word_cnt_o,
   output logic             overflow_o
);
   state_e           state_q, state_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [AddrW:0]   cnt_q, cnt_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             we_q, we_d;
   logic             restart, word_vld;
   logic [31:0]      word;

   assign restart = prog_req_i && (state_q != LOAD);

   iccm_word_packer u_packer (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_i       (restart),
      .en_i        (state_q == LOAD),
      .valid_i     (rx_valid_i),
      .byte_i      (rx_byte_i),
      .word_o      (word),
      .word_valid_o(word_vld)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= LOAD;
         addr_q  <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // Address and count advance at the end of the write cycle; words are >= 4 cycles apart.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      if (we_q) begin
         addr_d = addr_q + AddrW'(1);
         cnt_d  = cnt_q + (AddrW + 1)'(1);
      end
      if (restart) begin
         state_d = LOAD;
         addr_d  = '0;
         cnt_d   = '0;
      end else if (word_vld) begin
         if (word == EndWord) state_d = DONE;
         else if (cnt_q[AddrW]) state_d = ERR;
         else begin
            we_d    = 1'b1;
            wdata_d = word;
         end
      end
   end

   assign iccm_ctrl_addr_o  = addr_q;
   assign iccm_ctrl_wdata_o = wdata_q;
   assign iccm_ctrl_we_o    = we_q;
   assign prog_rst_no       = (state_q != LOAD);
   assign word_cnt_o        = cnt_q;
   assign overflow_o        = (state_q == ERR);
endmodule
